// File: rtl/event_arbiter_pkg.sv
// Shared event encoding, arbitration state and helpers for the event arbiter.
// Bit order of every event vector: UP, DOWN, RIGHT, LEFT, SPACE, FALL.
package event_arbiter_pkg;

  localparam int EVENT_LEN       = 6;
  localparam int LEVEL_LEN       = 4;
  localparam int EVENT_KEY_UP    = 0;
  localparam int EVENT_KEY_DOWN  = 1;
  localparam int EVENT_KEY_RIGHT = 2;
  localparam int EVENT_KEY_LEFT  = 3;
  localparam int EVENT_KEY_SPACE = 4;
  localparam int EVENT_FALL      = 5;

  typedef logic [EVENT_LEN-1:0] event_t;

  localparam event_t SPACE_MASK = 6'b010000;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Fixed priority from bit 0 upward, unless a starved FALL jumps the queue.
  function automatic event_t pick_winner(input event_t req, input logic fall_first);
    event_t win;
    win = '0;
    if (fall_first && req[EVENT_FALL]) begin
      win[EVENT_FALL] = 1'b1;
    end else begin
      for (int i = 0; i < EVENT_LEN; i++) begin
        if (req[i] && (win == '0)) win[i] = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [2:0] count_ones(input logic [4:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 5; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/event_arbiter_if.sv
// One-hot grant/acknowledge handshake between the event arbiter and the game FSM.
// The arbiter is the master: it owns event_out; the FSM returns fsm_ready and event_received.
interface event_arbiter_if;
  import event_arbiter_pkg::*;

  event_t event_out;
  event_t event_received;
  logic   fsm_ready;

  modport master (output event_out, input event_received, input fsm_ready);
  modport slave  (input event_out, output event_received, output fsm_ready);

endinterface

// File: rtl/event_arbiter_fall_timer.sv
// Gravity timer: level-dependent period, counts only while enabled, tick is combinational
// on the final count so the FALL request lands on the same edge the counter wraps.
module event_arbiter_fall_timer
  import event_arbiter_pkg::*;
#(
  parameter logic [23:0] BASE_PERIOD = 24'd4000,
  parameter logic [23:0] STEP        = 24'd250,
  parameter logic [23:0] MIN_PERIOD  = 24'd250
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [LEVEL_LEN-1:0] level,
  input  logic                 restart,
  output logic                 tick
);

  logic [23:0] count;
  logic [23:0] reduction;
  logic [23:0] period;

  // Guard against BASE_PERIOD - reduction wrapping when STEP is large.
  always_comb begin
    reduction = 24'(level) * STEP;
    if ((reduction >= BASE_PERIOD) || ((BASE_PERIOD - reduction) < MIN_PERIOD)) begin
      period = MIN_PERIOD;
    end else begin
      period = BASE_PERIOD - reduction;
    end
  end

  assign tick = enable && (count >= (period - 24'd1));

  always_ff @(posedge clk) begin
    if (rst || !enable || restart || tick) begin
      count <= '0;
    end else begin
      count <= count + 24'd1;
    end
  end

endmodule

// File: rtl/event_arbiter.sv
// Pends key presses and gravity ticks, grants one at a time over a one-hot req/ack handshake.
// Grant registers one edge after a request is pending; at least one idle cycle follows every ack.
module event_arbiter
  import event_arbiter_pkg::*;
#(
  parameter logic [23:0] BASE_PERIOD  = 24'd4000,
  parameter logic [23:0] STEP         = 24'd250,
  parameter logic [23:0] MIN_PERIOD   = 24'd250,
  parameter logic [15:0] STARVE_LIMIT = 16'd2000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           key_press,
  input  logic [LEVEL_LEN-1:0] level,
  input  logic                 enable,
  event_arbiter_if.master      bus,
  output logic [7:0]           dropped_cnt,
  output logic                 protocol_err
);

  arb_state_t  state, state_nxt;
  event_t      pending, pending_nxt;
  event_t      grant_nxt;
  event_t      allow;
  event_t      req_set;
  event_t      ack_clr;
  logic [4:0]  drops;
  logic [8:0]  drop_sum;
  logic [7:0]  dropped_nxt;
  logic [15:0] age, age_nxt;
  logic        tick;
  logic        ack_match;
  logic        ack_bad;
  logic        perr_nxt;

  event_arbiter_fall_timer #(
    .BASE_PERIOD (BASE_PERIOD),
    .STEP        (STEP),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_fall_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .level   (level),
    .restart (ack_clr[EVENT_KEY_DOWN]),
    .tick    (tick)
  );

  // On the start screen only SPACE may pend or win.
  assign allow     = enable ? '1 : SPACE_MASK;
  assign ack_match = (state == GRANT) && (bus.event_received == bus.event_out);
  assign ack_bad   = (state == GRANT) && (bus.event_received != '0) && !ack_match;
  assign ack_clr   = ack_match ? bus.event_out : '0;
  assign req_set   = {tick, key_press} & allow;

  // A press on the acked bit is a fresh request, not a drop; gravity never counts.
  always_comb begin
    drops       = key_press & allow[4:0] & pending[4:0] & ~ack_clr[4:0];
    drop_sum    = {1'b0, dropped_cnt} + {6'b0, count_ones(drops)};
    dropped_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    pending_nxt = ((pending & ~ack_clr) | req_set) & allow;
  end

  always_comb begin
    if (ack_clr[EVENT_FALL] || !pending[EVENT_FALL]) begin
      age_nxt = '0;
    end else if (!bus.event_out[EVENT_FALL] && (age != 16'hFFFF)) begin
      age_nxt = age + 16'd1;
    end else begin
      age_nxt = age;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = bus.event_out;
    perr_nxt  = protocol_err;
    case (state)
      IDLE: begin
        if (bus.fsm_ready && ((pending & allow) != '0)) begin
          grant_nxt = pick_winner(pending & allow, age >= STARVE_LIMIT);
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (ack_match) begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end else if (ack_bad) begin
          perr_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pending       <= '0;
      age           <= '0;
      dropped_cnt   <= '0;
      protocol_err  <= 1'b0;
      bus.event_out <= '0;
    end else begin
      state         <= state_nxt;
      pending       <= pending_nxt;
      age           <= age_nxt;
      dropped_cnt   <= dropped_nxt;
      protocol_err  <= perr_nxt;
      bus.event_out <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_event_arbiter.sv
// Randomized and directed bench for event_arbiter against an event-level reference model.
module tb_event_arbiter;

  logic       clk;
  logic       rst;
  logic [4:0] key_press;
  logic [3:0] level;
  logic       enable;
  logic [7:0] dropped_cnt;
  logic       protocol_err;
  logic       ft_en;
  logic [3:0] ft_level;
  logic       ft_tick;

  event_arbiter_if bus();

  event_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .key_press    (key_press),
    .level        (level),
    .enable       (enable),
    .bus          (bus),
    .dropped_cnt  (dropped_cnt),
    .protocol_err (protocol_err)
  );

  // Separate timer with a large step to show the period clamps instead of wrapping.
  event_arbiter_fall_timer #(.STEP(24'd300)) ft (
    .clk     (clk),
    .rst     (rst),
    .enable  (ft_en),
    .level   (ft_level),
    .restart (1'b0),
    .tick    (ft_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;
  bit auto_ack = 0;

  // Reference model: pending requests as flags, outstanding grant as an index (-1 = none).
  int m_timer = 0;
  bit m_pend [6];
  int m_grant = -1;
  int m_age = 0;
  int m_drops = 0;
  bit m_perr = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_out();
    return (m_grant < 0) ? 0 : (1 << m_grant);
  endfunction

  function automatic bit allowed(input int i, input bit en);
    return en || (i == 4);
  endfunction

  always @(posedge clk) begin : model
    int period;
    int og;
    int w;
    bit tick;
    bit acked;
    bit op [6];
    if (rst) begin
      m_timer = 0;
      m_grant = -1;
      m_age = 0;
      m_drops = 0;
      m_perr = 0;
      for (int i = 0; i < 6; i++) m_pend[i] = 0;
    end else begin
      period = 4000 - int'(level) * 250;
      if (period < 250) period = 250;
      tick = enable && (m_timer >= period - 1);
      og = m_grant;
      acked = (og >= 0) && (int'(bus.event_received) == (1 << og));
      for (int i = 0; i < 6; i++) op[i] = m_pend[i];

      // handshake, decided on the state before this edge
      if (og < 0) begin
        if (bus.fsm_ready) begin
          w = -1;
          if (op[5] && enable && (m_age >= 2000)) w = 5;
          for (int i = 0; i < 6; i++)
            if (w < 0 && op[i] && allowed(i, enable)) w = i;
          m_grant = w;
        end
      end else if (acked) begin
        m_grant = -1;
      end else if (bus.event_received != 0) begin
        m_perr = 1;
      end

      if (!op[5] || (acked && og == 5)) m_age = 0;
      else if (og != 5 && m_age < 65535) m_age++;

      if (!enable || tick || (acked && og == 1)) m_timer = 0;
      else m_timer++;

      for (int i = 0; i < 5; i++) begin
        bit kept;
        kept = op[i] && !(acked && og == i);
        if (key_press[i] && allowed(i, enable)) begin
          if (kept && m_drops < 255) m_drops++;
          m_pend[i] = 1;
        end else begin
          m_pend[i] = kept && allowed(i, enable);
        end
      end
      m_pend[5] = enable && ((op[5] && !(acked && og == 5)) || tick);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("event_out", bus.event_out, exp_out());
      check("dropped_cnt", dropped_cnt, m_drops);
      check("protocol_err", protocol_err, m_perr);
    end
  end

  task automatic cyc();
    @(negedge clk);
    if (auto_ack) bus.event_received = bus.event_out;
  endtask

  task automatic count_to_grant(input logic [5:0] want, input int limit, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (bus.event_out != want && n < limit);
  endtask

  task automatic quiesce();
    enable = 0;
    key_press = '0;
    auto_ack = 1;
    repeat (3) cyc();
    auto_ack = 0;
    bus.event_received = '0;
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1;
    key_press = '0;
    level = '0;
    enable = 0;
    ft_en = 1;
    ft_level = 4'd15;
    bus.fsm_ready = 0;
    bus.event_received = '0;
    repeat (3) cyc();
    check("reset_event_out", bus.event_out, 0);
    check("reset_dropped", dropped_cnt, 0);
    check("reset_perr", protocol_err, 0);
    chk_en = 1;

    // gravity at level 0, FSM acks one cycle after each grant
    rst = 0;
    level = 0;
    bus.fsm_ready = 1;
    auto_ack = 1;
    enable = 1;
    count_to_grant(6'b100000, 5000, n);
    check("first_fall_cycle", n, 4001);
    count_to_grant(6'b100000, 5000, n);
    check("fall_period_lvl0", n, 4000);

    level = 4'd15;
    count_to_grant(6'b100000, 1000, n);
    check("fall_first_lvl15", n, 250);
    count_to_grant(6'b100000, 1000, n);
    check("fall_period_lvl15", n, 250);

    n = 0;
    do begin cyc(); n++; end while (!ft_tick && n < 1000);
    n = 0;
    do begin cyc(); n++; end while (!ft_tick && n < 1000);
    check("clamp_step300", n, 250);

    // UP and LEFT together: UP first, one idle cycle after its ack, then LEFT
    level = 0;
    quiesce();
    enable = 1;
    key_press = 5'b01001;
    cyc();
    key_press = '0;
    cyc();
    check("up_first", bus.event_out, 6'b000001);
    bus.event_received = 6'b000001;
    cyc();
    bus.event_received = '0;
    check("ack_clears", bus.event_out, 0);
    cyc();
    check("left_after_idle", bus.event_out, 6'b001000);
    bus.event_received = 6'b001000;
    cyc();
    bus.event_received = '0;

    // repeated RIGHT while still pending
    bus.fsm_ready = 0;
    repeat (3) begin
      key_press = 5'b00100;
      cyc();
      key_press = '0;
      cyc();
    end
    check("drop_cnt", dropped_cnt, 2);
    check("no_grant_not_ready", bus.event_out, 0);
    bus.fsm_ready = 1;
    cyc();
    check("right_grant", bus.event_out, 6'b000100);
    bus.event_received = 6'b000100;
    cyc();
    bus.event_received = '0;
    seen = 0;
    repeat (6) begin
      cyc();
      if (bus.event_out != 0) seen = 1;
    end
    check("no_right_regrant", seen, 0);

    // mismatched ack
    key_press = 5'b00010;
    cyc();
    key_press = '0;
    cyc();
    check("down_grant", bus.event_out, 6'b000010);
    bus.event_received = 6'b000001;
    cyc();
    bus.event_received = '0;
    check("perr_set", protocol_err, 1);
    check("perr_grant_held", bus.event_out, 6'b000010);
    cyc();
    check("grant_still_held", bus.event_out, 6'b000010);
    bus.event_received = 6'b000010;
    cyc();
    bus.event_received = '0;

    // starvation: UP requested every cycle, FALL still wins once aged
    quiesce();
    enable = 1;
    level = 4'd15;
    key_press = 5'b00001;
    auto_ack = 1;
    count_to_grant(6'b100000, 3000, n);
    check("starved_fall_cycle", n, 2252);
    key_press = '0;
    repeat (6) cyc();

    // start screen: only SPACE
    quiesce();
    bus.fsm_ready = 1;
    key_press = 5'b11000;
    cyc();
    key_press = '0;
    cyc();
    check("space_only", bus.event_out, 6'b010000);
    bus.event_received = 6'b010000;
    cyc();
    bus.event_received = '0;
    seen = 0;
    repeat (5) begin
      cyc();
      if (bus.event_out != 0) seen = 1;
    end
    check("no_left_on_start", seen, 0);

    // reset while a grant is outstanding
    enable = 1;
    key_press = 5'b10000;
    cyc();
    key_press = '0;
    cyc();
    check("pre_reset_grant", bus.event_out, 6'b010000);
    rst = 1;
    cyc();
    check("rst_event_out", bus.event_out, 0);
    check("rst_dropped", dropped_cnt, 0);
    check("rst_perr", protocol_err, 0);
    rst = 0;

    // randomized traffic
    for (int c = 0; c < 15000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 499) == 0) enable = ~enable;
      if ($urandom_range(0, 299) == 0) level = 4'($urandom_range(0, 15));
      for (int b = 0; b < 5; b++) key_press[b] = ($urandom_range(0, 15) == 0);
      bus.fsm_ready = ($urandom_range(0, 3) != 0);
      if (bus.event_out == 0) begin
        bus.event_received = '0;
      end else if ($urandom_range(0, 39) == 0) begin
        bus.event_received = 6'(1 << $urandom_range(0, 5));
      end else if ($urandom_range(0, 2) == 0) begin
        bus.event_received = bus.event_out;
      end else begin
        bus.event_received = '0;
      end
    end
    @(negedge clk);
    rst = 0;
    key_press = '0;
    bus.event_received = '0;
    repeat (2) @(negedge clk);
    chk_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/event_arbiter.md
Name: event_arbiter

Overview:
- Collects keyboard action pulses and a level-dependent gravity tick.
- Holds each as a pending request and grants exactly one at a time to the game FSM over a one-hot request/acknowledge handshake.
- Replaces the ad-hoc event_out/event_received pairing between the keyboard decoder and the main game FSM.
- Sits on main_clk between the PS/2 key decoder and the game FSM; also owns the fall-speed schedule.

Parameters:
- BASE_PERIOD, 24'd4000: gravity period in clk cycles at level 0.
- STEP, 24'd250: period reduction per level.
- MIN_PERIOD, 24'd250: lower clamp on the gravity period.
- STARVE_LIMIT, 16'd2000: cycles a pending FALL may wait before it is promoted to top priority.

Ports:
- clk  input  1  main game clock.
- rst  input  1  synchronous, active-high reset.
- key_press  input  5  one-cycle pulses; bit0 UP, bit1 DOWN, bit2 RIGHT, bit3 LEFT, bit4 SPACE.
- level  input  4  current level, 0..15.
- enable  input  1  1 = game playing; 0 = START screen.
- fsm_ready  input  1  game FSM is in WAIT and able to accept an event.
- event_received  input  6  acknowledge; one-hot, same bit order as event_out.
- event_out  output  6  one-hot grant; bits 0-4 follow key_press order, bit5 is FALL.
- dropped_cnt  output  8  saturating count of presses lost because the same request was already pending.
- protocol_err  output  1  sticky flag; set by an ack that does not match the outstanding grant.

Behaviour:
- Reset: every output is 0; pending = 0; fall timer = 0; state = IDLE.
- Pending register, 6 bits:
  - A key_press bit sets the matching pending bit on the next edge.
  - If that bit is already pending, the press is absorbed and dropped_cnt increments (saturates at 255).
- Gravity:
  - period = max(BASE_PERIOD - level*STEP, MIN_PERIOD), computed at 24-bit width with an underflow guard.
  - The timer counts only while enable=1.
  - When timer >= period-1: timer goes to 0 and pending[FALL] is set.
  - An acknowledged DOWN also resets the timer to 0 (soft drop restarts gravity).
  - A level change takes effect on the next compare; there is no timer reset.
- enable = 0:
  - Timer is held at 0.
  - Pending bits 0-3 and 5 are cleared every cycle.
  - Only SPACE can pend or be granted.
- Priority: UP > DOWN > RIGHT > LEFT > SPACE > FALL.
- Starvation promotion:
  - An age counter (16 bits, saturating) runs while pending[FALL]=1 and FALL is not granted.
  - When age >= STARVE_LIMIT, FALL becomes top priority.
  - Age clears when FALL is acknowledged.
- FSM states:
  - IDLE: if fsm_ready=1 and pending != 0, register the winner into event_out and go to GRANT.
  - GRANT:
    - event_out is held stable regardless of fsm_ready.
    - When event_received == event_out: clear that pending bit and event_out on the same edge, then go to IDLE.
    - Any other nonzero event_received sets protocol_err and changes nothing else.
- Latency:
  - Press sampled at edge t → pending at t → event_out visible after edge t+1 (if idle and ready).
  - Ack at edge u → at least one idle cycle before the next grant (earliest grant after edge u+1).
- Simultaneous events:
  - A press of the same key in the cycle its grant is acknowledged re-sets pending; it is a new request, not a drop.
  - A gravity tick while FALL is outstanding in GRANT is absorbed into the existing pending bit and does not count as a drop.
- Reset mid-grant: the outstanding event is discarded, with no ack required.

Decomposition:
- Shared package (header.v): EVENT_LEN=6; bit indices EVENT_KEY_UP/DOWN/RIGHT/LEFT/SPACE, EVENT_FALL; LEVEL_LEN=4.
- One sub-module, fall_timer: owns the period computation, the counter, and the tick/restart/hold inputs.
- Arbitration, aging and handshake stay in event_arbiter.

Test Plan:
- Reset, then enable=1, level=0, fsm_ready=1, and the ack is returned 1 cycle after each grant → event_out=6'b100000 every 4000 cycles; first tick at cycle 4000 after enable.
- level=15 → period clamps at 250 (4000-3750=250); level=15 with STEP=300 → period 250, not wrapped.
- key_press=UP|LEFT in the same cycle → event_out=000001; after its ack, one idle cycle, then event_out=001000.
- Press RIGHT three times while RIGHT is still pending (no ack) → dropped_cnt=2; after the ack, no further RIGHT grant.
- With fsm_ready=1, hold continuous UP presses with immediate acks, FALL pending → FALL is granted once age reaches 2000, ahead of the pending UP.
- Grant DOWN, then ack with 000001 → protocol_err=1 and event_out remains 000010. enable=0 with LEFT and SPACE pressed → only 010000 is granted. rst asserted during GRANT → all outputs 0 on the next edge.
